// File: rtl/viterbi_pkg.sv
// viterbi_pkg: constants and types shared by the Viterbi decoder core and
// the path reorder stage.
//   N_OBS    path length per frame (timesteps)
//   N_STATES number of HMM states; legal state values 0..N_STATES-1
//   STATE_W  width of a state index
//   IDX_W    width of a time index (2^IDX_W >= N_OBS)
package viterbi_pkg;
    localparam int N_OBS    = 140;
    localparam int N_STATES = 64;
    localparam int STATE_W  = 8;
    localparam int IDX_W    = 8;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef enum logic {FILL, DRAIN} path_fsm_t;

    // Sized copies of the limits so pointer/state compares stay width-matched.
    localparam idx_t   LAST_IDX  = idx_t'(N_OBS - 1);
    localparam state_t STATE_LIM = state_t'(N_STATES);
endpackage

// File: rtl/viterbi_path_reorder_if.sv
// viterbi_path_reorder_if: the two valid/ready streams around the reorder
// stage.
//   in_*  : reverse-time path from the backtrack (decoder side drives)
//   out_* : forward-time path to the consumer (reorder stage drives)
// modport master : decoder/consumer side (testbench)
// modport slave  : reorder stage
interface viterbi_path_reorder_if;
    import viterbi_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in_state;
    logic   in_last;

    logic   out_valid;
    logic   out_ready;
    state_t out_state;
    idx_t   out_index;
    logic   out_last;

    modport master (
        output in_valid, in_state, in_last, out_ready,
        input  in_ready, out_valid, out_state, out_index, out_last
    );

    modport slave (
        input  in_valid, in_state, in_last, out_ready,
        output in_ready, out_valid, out_state, out_index, out_last
    );
endinterface

// File: rtl/viterbi_path_mem.sv
// viterbi_path_mem: DEPTH x WIDTH register array, one synchronous write port
// and one combinational read port. Contents are not reset.
//   clk     clock
//   i_we    write enable
//   i_waddr write address
//   i_wdata write data
//   i_raddr read address
//   o_rdata read data (combinational from i_raddr)
module viterbi_path_mem #(
    parameter int DEPTH = 140,
    parameter int WIDTH = 8,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/viterbi_path_reorder.sv
// viterbi_path_reorder: captures the reverse-time backtrack path of one frame
// and replays it in forward time order.
//   clk, reset   clock, synchronous active-high reset
//   s_if         slave side of both path streams (in_* / out_*)
//   busy         high while draining or while a frame is partially captured
//   err_len      sticky: in_last arrived on the wrong beat
//   err_range    sticky: accepted state >= N_STATES
// Optional feature: define VITERBI_PATH_RANGE_CHK_EN to build the state range
// comparator; otherwise err_range is tied 0.
module viterbi_path_reorder
    import viterbi_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    viterbi_path_reorder_if.slave s_if,
    output logic                  busy,
    output logic                  err_len,
    output logic                  err_range
);
    path_fsm_t r_state;
    idx_t      r_wr_ptr;
    idx_t      r_wr_cnt;
    idx_t      r_rd_ptr;
    logic      r_err_len;

    logic      w_in_fire;
    logic      w_out_fire;
    logic      w_fill_done;
    state_t    w_rd_data;

    assign w_in_fire   = s_if.in_valid && (r_state == FILL);
    assign w_out_fire  = s_if.out_ready && (r_state == DRAIN);
    assign w_fill_done = (r_wr_cnt == LAST_IDX);

    viterbi_path_mem #(
        .DEPTH (N_OBS),
        .WIDTH (STATE_W),
        .AW    (IDX_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_in_fire),
        .i_waddr (r_wr_ptr),
        .i_wdata (s_if.in_state),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= FILL;
            r_wr_ptr  <= LAST_IDX;
            r_wr_cnt  <= '0;
            r_rd_ptr  <= '0;
            r_err_len <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_in_fire) begin
                        if (w_fill_done) begin
                            // Frame length is authoritative: drain even if
                            // in_last is missing, just flag it.
                            r_state  <= DRAIN;
                            r_wr_ptr <= r_wr_ptr - 1'b1;
                            r_wr_cnt <= r_wr_cnt + 1'b1;
                            if (!s_if.in_last) r_err_len <= 1'b1;
                        end else if (s_if.in_last) begin
                            // Short frame: drop what was captured and re-arm.
                            r_err_len <= 1'b1;
                            r_wr_ptr  <= LAST_IDX;
                            r_wr_cnt  <= '0;
                        end else begin
                            r_wr_ptr <= r_wr_ptr - 1'b1;
                            r_wr_cnt <= r_wr_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_out_fire) begin
                        if (r_rd_ptr == LAST_IDX) begin
                            r_state  <= FILL;
                            r_rd_ptr <= '0;
                            r_wr_ptr <= LAST_IDX;
                            r_wr_cnt <= '0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    // Handshake outputs decode straight from the state register.
    assign s_if.in_ready  = (r_state == FILL);
    assign s_if.out_valid = (r_state == DRAIN);
    assign s_if.out_state = w_rd_data;
    assign s_if.out_index = r_rd_ptr;
    assign s_if.out_last  = (r_rd_ptr == LAST_IDX);

    assign busy    = (r_state != FILL) || (r_wr_cnt != '0);
    assign err_len = r_err_len;

`ifdef VITERBI_PATH_RANGE_CHK_EN
    logic r_err_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_range <= 1'b0;
        end else if (w_in_fire && (s_if.in_state >= STATE_LIM)) begin
            // Out-of-range values are still stored and replayed.
            r_err_range <= 1'b1;
        end
    end

    assign err_range = r_err_range;
`else
    assign err_range = 1'b0;
`endif
endmodule
